// File: rtl/snitch_ro_cache_pkg.sv
// snitch_ro_cache_pkg: shared encodings, geometry helpers and burst-split helper
package snitch_ro_cache_pkg;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  typedef enum logic {IDLE, SPLIT} split_state_e;
  function automatic int unsigned calc_wpl(input int unsigned line_w, input int unsigned data_w);
    return line_w / data_w;
  endfunction
  function automatic int unsigned calc_bo(input int unsigned data_w);
    return $clog2(data_w / 8);
  endfunction
  function automatic int unsigned calc_lo(input int unsigned line_w);
    return $clog2(line_w / 8);
  endfunction
  function automatic logic [8:0] calc_beats(input logic [8:0] wpl, input logic [8:0] off, input logic [8:0] rem);
    logic [8:0] room;
    room = wpl - off;
    return room < rem ? room : rem;
  endfunction
endpackage

// File: rtl/snitch_ro_burst_split.sv
// snitch_ro_burst_split: turns one AR burst into line lookups plus metadata pushes
module snitch_ro_burst_split
  import snitch_ro_cache_pkg::*;
#(
  parameter int unsigned AxiAddrWidth = 48,
  parameter int unsigned AxiDataWidth = 64,
  parameter int unsigned AxiIdWidth = 4,
  parameter int unsigned LineWidth = 256,
  parameter int unsigned OffWidth = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ar_valid,
  output logic                    ar_ready,
  input  logic [AxiAddrWidth-1:0] ar_addr,
  input  logic [AxiIdWidth-1:0]   ar_id,
  input  logic [7:0]              ar_len,
  input  logic [2:0]              ar_size,
  input  logic [1:0]              ar_burst,
  input  logic                    meta_full,
  output logic                    lookup_valid,
  input  logic                    lookup_ready,
  output logic [AxiAddrWidth-1:0] lookup_addr,
  output logic [AxiIdWidth-1:0]   lookup_id,
  output logic                    push,
  output logic [AxiIdWidth-1:0]   push_id,
  output logic [OffWidth-1:0]     push_off,
  output logic [8:0]              push_beats,
  output logic                    push_err,
  output logic                    push_last
);
  localparam int unsigned WPL = calc_wpl(LineWidth, AxiDataWidth);
  localparam int unsigned BO = calc_bo(AxiDataWidth);
  localparam int unsigned LO = calc_lo(LineWidth);
  split_state_e state_q, state_d;
  logic [AxiAddrWidth-1:0] line_q;
  logic [OffWidth-1:0] off_q;
  logic [8:0] rem_q, beats;
  logic [AxiIdWidth-1:0] id_q;
  logic supported, ar_fire, req_fire;
  assign lookup_addr = line_q;
  assign lookup_id = id_q;
  always_comb begin
    supported = ar_burst == BURST_INCR && ar_size == 3'(BO);
    ar_ready = state_q == IDLE && !meta_full;
    lookup_valid = state_q == SPLIT && !meta_full;
    ar_fire = ar_valid && ar_ready;
    req_fire = lookup_valid && lookup_ready;
    beats = calc_beats(9'(WPL), 9'(off_q), rem_q);
    // unsupported bursts become a single error entry and never reach the cache
    push = (ar_fire && !supported) || req_fire;
    push_id = state_q == IDLE ? ar_id : id_q;
    push_off = state_q == IDLE ? '0 : off_q;
    push_beats = state_q == IDLE ? 9'(ar_len) + 9'd1 : beats;
    push_err = state_q == IDLE;
    push_last = state_q == IDLE || rem_q == beats;
    state_d = ar_fire && supported ? SPLIT : req_fire && rem_q == beats ? IDLE : state_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      line_q <= '0;
      off_q <= '0;
      rem_q <= '0;
      id_q <= '0;
    end else begin
      state_q <= state_d;
      if (ar_fire && supported) begin
        line_q <= (ar_addr >> LO) << LO;
        off_q <= OffWidth'((ar_addr >> BO) & AxiAddrWidth'(WPL - 1));
        rem_q <= 9'(ar_len) + 9'd1;
        id_q <= ar_id;
      end else if (req_fire) begin
        line_q <= line_q + AxiAddrWidth'(LineWidth / 8);
        off_q <= '0;
        rem_q <= rem_q - beats;
      end
    end
  end
endmodule

// File: rtl/snitch_ro_cache_burst_frontend.sv
// snitch_ro_cache_burst_frontend: AXI read front-end splitting INCR bursts into line lookups
module snitch_ro_cache_burst_frontend
  import snitch_ro_cache_pkg::*;
#(
  parameter int unsigned AxiAddrWidth = 48,
  parameter int unsigned AxiDataWidth = 64,
  parameter int unsigned AxiIdWidth = 4,
  parameter int unsigned LineWidth = 256,
  parameter int unsigned MetaDepth = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    ar_valid_i,
  output logic                    ar_ready_o,
  input  logic [AxiAddrWidth-1:0] ar_addr_i,
  input  logic [AxiIdWidth-1:0]   ar_id_i,
  input  logic [7:0]              ar_len_i,
  input  logic [2:0]              ar_size_i,
  input  logic [1:0]              ar_burst_i,
  output logic                    r_valid_o,
  input  logic                    r_ready_i,
  output logic [AxiDataWidth-1:0] r_data_o,
  output logic [AxiIdWidth-1:0]   r_id_o,
  output logic [1:0]              r_resp_o,
  output logic                    r_last_o,
  output logic                    lookup_req_valid_o,
  input  logic                    lookup_req_ready_i,
  output logic [AxiAddrWidth-1:0] lookup_req_addr_o,
  output logic [AxiIdWidth-1:0]   lookup_req_id_o,
  input  logic                    lookup_rsp_valid_i,
  output logic                    lookup_rsp_ready_o,
  input  logic [LineWidth-1:0]    lookup_rsp_data_i,
  input  logic                    lookup_rsp_error_i
);
  localparam int unsigned WPL = calc_wpl(LineWidth, AxiDataWidth);
  localparam int unsigned OW = WPL > 1 ? $clog2(WPL) : 1;
  localparam int unsigned PW = MetaDepth > 1 ? $clog2(MetaDepth) : 1;
  localparam int unsigned CW = $clog2(MetaDepth + 1);
  typedef struct packed {
    logic [AxiIdWidth-1:0] id;
    logic [OW-1:0] off;
    logic [8:0] beats;
    logic err;
    logic last;
  } meta_t;
  meta_t mem_q [MetaDepth];
  meta_t head, push_meta;
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic [7:0] k_q;
  logic [OW-1:0] widx;
  logic empty, full, live, fin, push, pop, r_valid, ar_ready, req_valid;
  logic [AxiIdWidth-1:0] p_id;
  logic [OW-1:0] p_off;
  logic [8:0] p_beats;
  logic p_err, p_last;
  snitch_ro_burst_split #(
    .AxiAddrWidth(AxiAddrWidth),
    .AxiDataWidth(AxiDataWidth),
    .AxiIdWidth(AxiIdWidth),
    .LineWidth(LineWidth),
    .OffWidth(OW)
  ) i_split (
    .clk(clk_i),
    .rst(rst_i),
    .ar_valid(ar_valid_i),
    .ar_ready(ar_ready),
    .ar_addr(ar_addr_i),
    .ar_id(ar_id_i),
    .ar_len(ar_len_i),
    .ar_size(ar_size_i),
    .ar_burst(ar_burst_i),
    .meta_full(full && !pop),
    .lookup_valid(req_valid),
    .lookup_ready(lookup_req_ready_i),
    .lookup_addr(lookup_req_addr_o),
    .lookup_id(lookup_req_id_o),
    .push(push),
    .push_id(p_id),
    .push_off(p_off),
    .push_beats(p_beats),
    .push_err(p_err),
    .push_last(p_last)
  );
  assign push_meta = {p_id, p_off, p_beats, p_err, p_last};
  assign ar_ready_o = ar_ready && !rst_i;
  assign lookup_req_valid_o = req_valid && !rst_i;
  assign r_valid_o = r_valid;
  always_comb begin
    head = mem_q[rd_q];
    empty = cnt_q == '0;
    full = cnt_q == CW'(MetaDepth);
    live = !empty && !rst_i;
    fin = 9'(k_q) == head.beats - 9'd1;
    widx = head.off + OW'(k_q);
    // error entries stream DECERR on their own; data entries follow the held line
    r_valid = live && (head.err || lookup_rsp_valid_i);
    pop = r_valid && r_ready_i && fin;
    r_data_o = !live || head.err ? '0 : lookup_rsp_data_i[widx*AxiDataWidth +: AxiDataWidth];
    r_id_o = live ? head.id : '0;
    r_resp_o = !live ? RESP_OKAY : head.err ? RESP_DECERR : lookup_rsp_error_i ? RESP_SLVERR : RESP_OKAY;
    r_last_o = r_valid && head.last && fin;
    lookup_rsp_ready_o = r_valid && !head.err && fin && r_ready_i;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      k_q <= '0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= push_meta;
        wr_q <= wr_q == PW'(MetaDepth - 1) ? '0 : wr_q + 1'b1;
      end
      if (pop) rd_q <= rd_q == PW'(MetaDepth - 1) ? '0 : rd_q + 1'b1;
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
      if (r_valid && r_ready_i) k_q <= fin ? '0 : k_q + 8'd1;
    end
  end
  assert property (@(posedge clk_i) disable iff (rst_i) !(lookup_rsp_valid_i && empty));
endmodule
